// File: rtl/width_conv_pkg.sv
// Shared types and sizing helpers for the width converters.
// Used by both the upsizer and the downsizer.
package width_conv_pkg;

    typedef enum logic {FILL, PEND} upsz_state_e;

    function automatic int ratio(input int in_b, input int out_b);
        return out_b / in_b;
    endfunction

    function automatic int lane_idx_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    localparam int LANE_IDX_W = lane_idx_w(ratio(32, 128));

endpackage

// File: rtl/wc_out_slot.sv
// Single-entry output register: load, hold while stalled, drain on ready.
// Reset is asynchronous and active-high.
module wc_out_slot #(
    parameter int DW = 1024,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic [KW-1:0] i_keep,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [KW-1:0] o_keep,
    output logic          o_valid
);

    logic [DW-1:0] r_data;
    logic [KW-1:0] r_keep;
    logic          r_valid;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_valid = r_valid;

endmodule

// File: rtl/width_upsizer.sv
// Packs IN_BYTES beats into OUT_BYTES words with a lane-valid mask.
// Accumulator plus output slot keep the input at full rate.
module width_upsizer
    import width_conv_pkg::*;
#(
    parameter int IN_BYTES  = 32,
    parameter int OUT_BYTES = 128,
    localparam int RATIO = ratio(IN_BYTES, OUT_BYTES),
    localparam int LB    = IN_BYTES * 8,
    localparam int OW    = OUT_BYTES * 8,
    localparam int CW    = lane_idx_w(RATIO)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [LB-1:0]    s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [OW-1:0]    m_data,
    output logic [RATIO-1:0] m_keep,
    output logic             m_valid,
    input  logic             m_ready
);

    if ((OUT_BYTES % IN_BYTES) != 0 || RATIO < 2) begin : g_bad_cfg
        $error("width_upsizer: OUT_BYTES must be a multiple >= 2 of IN_BYTES");
    end

    upsz_state_e      r_state;
    logic [OW-1:0]    r_acc;
    logic [RATIO-1:0] r_kacc;
    logic [CW-1:0]    r_cnt;

    logic             w_fire;
    logic             w_done;
    logic             w_free;
    logic             w_pend_go;
    logic             w_load;
    logic [OW-1:0]    w_pdata;
    logic [RATIO-1:0] w_pkeep;
    logic [OW-1:0]    w_ldata;
    logic [RATIO-1:0] w_lkeep;

    assign s_ready   = (r_state == FILL) && !rstn;
    assign w_fire    = s_valid && s_ready;
    assign w_done    = w_fire && (s_last || r_cnt == CW'(RATIO - 1));
    assign w_free    = !m_valid || m_ready;
    assign w_pend_go = (r_state == PEND) && m_ready;
    assign w_load    = w_pend_go || (w_done && w_free);

    // Accumulator with the incoming beat merged into lane r_cnt.
    always_comb begin
        w_pdata = r_acc;
        w_pkeep = r_kacc;
        w_pdata[int'(r_cnt)*LB +: LB] = s_data;
        w_pkeep[r_cnt] = 1'b1;
    end

    assign w_ldata = w_pend_go ? r_acc  : w_pdata;
    assign w_lkeep = w_pend_go ? r_kacc : w_pkeep;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= FILL;
            r_acc   <= '0;
            r_kacc  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_done) begin
                        r_cnt <= '0;
                        if (w_free) begin
                            r_acc  <= '0;
                            r_kacc <= '0;
                        end else begin
                            r_acc   <= w_pdata;
                            r_kacc  <= w_pkeep;
                            r_state <= PEND;
                        end
                    end else if (w_fire) begin
                        r_acc  <= w_pdata;
                        r_kacc <= w_pkeep;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                PEND: begin
                    if (m_ready) begin
                        r_acc   <= '0;
                        r_kacc  <= '0;
                        r_state <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    wc_out_slot #(
        .DW(OW),
        .KW(RATIO)
    ) u_slot (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (w_load),
        .i_data (w_ldata),
        .i_keep (w_lkeep),
        .i_ready(m_ready),
        .o_data (m_data),
        .o_keep (m_keep),
        .o_valid(m_valid)
    );

endmodule
